// File: rtl/frame_ds_pkg.sv
// Shared state type and default geometry for the camera frame downsampler.
package frame_ds_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE} ds_state_t;

  localparam int IMG_W_DEF   = 640;
  localparam int IMG_H_DEF   = 480;
  localparam int X_OFF_DEF   = 96;
  localparam int Y_OFF_DEF   = 16;
  localparam int BLK_DEF     = 16;
  localparam int OUT_DIM_DEF = 28;
  localparam int PIX_W_DEF   = 8;
  localparam int ADDR_W      = 10;

  localparam int WIN       = OUT_DIM_DEF * BLK_DEF;
  localparam int SHIFT     = 2 * $clog2(BLK_DEF);
  localparam int ACC_W     = PIX_W_DEF + SHIFT;
  localparam int LAST_ADDR = OUT_DIM_DEF * OUT_DIM_DEF - 1;

endpackage

// File: rtl/ds_col_accum.sv
// Bank of per-column block accumulators; one slot per output column of the current block row.
module ds_col_accum
  import frame_ds_pkg::*;
#(
  parameter int OUT_DIM = OUT_DIM_DEF,
  parameter int PIX_W   = PIX_W_DEF,
  parameter int SUM_W   = ACC_W,
  parameter int IDX_W   = $clog2(OUT_DIM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             add_en,
  input  logic             clr_en,
  input  logic             clr_all,
  input  logic [IDX_W-1:0] idx,
  input  logic [PIX_W-1:0] data,
  output logic [SUM_W-1:0] sum
);

  logic [SUM_W-1:0] acc [OUT_DIM];
  logic [SUM_W-1:0] base;

  // A frame restart zeroes the bank and the restarting pixel lands on an empty slot.
  assign base = clr_all ? '0 : acc[idx];
  assign sum  = base + SUM_W'(data);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
    end else begin
      if (clr_all) begin
        for (int i = 0; i < OUT_DIM; i++) acc[i] <= '0;
      end
      if (clr_en) begin
        acc[idx] <= '0;
      end else if (add_en) begin
        acc[idx] <= sum;
      end
    end
  end

endmodule

// File: rtl/frame_downsampler.sv
// Crops a centred square window from the camera stream and box-averages it into an
// OUT_DIM x OUT_DIM image written to image_mem. Define FRAME_DS_INVERT_EN to invert output pixels.
module frame_downsampler
  import frame_ds_pkg::*;
#(
  parameter int IMG_W   = IMG_W_DEF,
  parameter int IMG_H   = IMG_H_DEF,
  parameter int X_OFF   = X_OFF_DEF,
  parameter int Y_OFF   = Y_OFF_DEF,
  parameter int BLK     = BLK_DEF,
  parameter int OUT_DIM = OUT_DIM_DEF,
  parameter int PIX_W   = PIX_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pix_vld,
  input  logic              pix_sof,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              busy,
  output logic              done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [PIX_W-1:0]  mem_wdata
);

  localparam int LB        = $clog2(BLK);
  localparam int SUM_SHIFT = 2 * LB;
  localparam int SUM_W     = PIX_W + SUM_SHIFT;
  localparam int WIN_PX    = OUT_DIM * BLK;
  localparam int XW        = $clog2(IMG_W + 1);
  localparam int YW        = $clog2(IMG_H + 1);
  localparam int BXW       = $clog2(OUT_DIM);

  localparam logic [XW-1:0]     X_LO   = XW'(X_OFF);
  localparam logic [XW-1:0]     X_HI   = XW'(X_OFF + WIN_PX);
  localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     Y_LO   = YW'(Y_OFF);
  localparam logic [YW-1:0]     Y_HI   = YW'(Y_OFF + WIN_PX);
  localparam logic [YW-1:0]     Y_SAT  = YW'(IMG_H);
  localparam logic [ADDR_W-1:0] OD_A   = ADDR_W'(OUT_DIM);
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(OUT_DIM * OUT_DIM - 1);

  function automatic logic [PIX_W-1:0] fmt_pix(input logic [PIX_W-1:0] avg);
`ifdef FRAME_DS_INVERT_EN
    return {PIX_W{1'b1}} - avg;
`else
    return avg;
`endif
  endfunction

  ds_state_t        state, state_nxt;
  logic             done_nxt;
  logic [XW-1:0]    x_cnt, cur_x, xr;
  logic [YW-1:0]    y_cnt, cur_y, yr;
  logic             last_wr, take, restart, in_win, blk_end;
  logic [BXW-1:0]   bx, by;
  logic [SUM_W-1:0] blk_sum;
  logic             unused_bits;

  // Once the final block is written the rest of the frame is ignored.
  assign last_wr = mem_we && (mem_waddr == LAST_A);
  assign take    = pix_vld && !last_wr &&
                   ((state == CAPTURE) || ((state == WAIT_SOF) && pix_sof));
  assign restart = take && pix_sof;

  assign cur_x   = pix_sof ? '0 : x_cnt;
  assign cur_y   = pix_sof ? '0 : y_cnt;
  assign xr      = cur_x - X_LO;
  assign yr      = cur_y - Y_LO;
  assign in_win  = take && (cur_x >= X_LO) && (cur_x < X_HI) &&
                   (cur_y >= Y_LO) && (cur_y < Y_HI);
  assign bx      = xr[LB +: BXW];
  assign by      = yr[LB +: BXW];
  assign blk_end = in_win && (&xr[LB-1:0]) && (&yr[LB-1:0]);

  assign busy        = (state != IDLE);
  assign unused_bits = ^{xr, yr, blk_sum};

  ds_col_accum #(
    .OUT_DIM (OUT_DIM),
    .PIX_W   (PIX_W),
    .SUM_W   (SUM_W),
    .IDX_W   (BXW)
  ) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .add_en  (in_win),
    .clr_en  (blk_end),
    .clr_all (restart),
    .idx     (bx),
    .data    (pix_data),
    .sum     (blk_sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = done;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = WAIT_SOF;
          done_nxt  = 1'b0;
        end
      end
      WAIT_SOF: begin
        if (pix_vld && pix_sof) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (last_wr) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Raster position of the next pixel; y parks at IMG_H past the last row.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (take) begin
      if (cur_x == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= (cur_y == Y_SAT) ? cur_y : cur_y + 1'b1;
      end else begin
        x_cnt <= cur_x + 1'b1;
        y_cnt <= cur_y;
      end
    end
  end

  // Write stage: one cycle after the block's last pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= blk_end;
      if (blk_end) begin
        mem_waddr <= ADDR_W'(by) * OD_A + ADDR_W'(bx);
        mem_wdata <= fmt_pix(blk_sum[SUM_SHIFT +: PIX_W]);
      end
    end
  end

endmodule
